// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: pops one FIFO word per channel slot and shifts it
// out MSB-first on sd, for Philips (one-bit delayed) and MSB-justified modes.
// Optional feature macro: I2S_TX_UNDERRUN_HOLD_EN -- an underrun slot repeats
// the last popped word instead of sending zeros.
module i2s_tx_serializer #(
   parameter int unsigned DW = 32
) (
   input  logic          sclk,
   input  logic          rst_,
   input  logic          ws,
   input  logic          Tx_ren,
   input  logic          del_Tx_ren,
   input  logic          standard,
   input  logic [1:0]    frame_size,
   input  logic [DW-1:0] fifo_data,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   output logic          sd,
   output logic          ch,
   output logic          underrun,
   input  logic          underrun_clr
);

   localparam int unsigned SW = 32;           // widest slot
   localparam int unsigned CW = $clog2(SW);   // bit counter width

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t         state_q, state_nx;
   logic [SW-1:0]  shreg_q, shreg_nx;
   logic [CW-1:0]  cnt_q, cnt_nx;
   logic           ws_q, wsx_q, en_q;
   logic           sd_nx, fifo_rd_nx, ch_nx, underrun_nx;
   logic           en_c, wsx_c, boundary_c;
   logic [SW-1:0]  hold_c, src_c, src_al_c;
   logic [CW-1:0]  n_m1_c;

   // Mode-dependent enable and word select, and slot boundary detect
   always_comb begin
      en_c       = standard ? Tx_ren : del_Tx_ren;
      wsx_c      = standard ? ws : ws_q;
      boundary_c = en_c & ((wsx_c != wsx_q) | ~en_q);
   end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
   logic [SW-1:0] last_q;

   // Remember the last word actually popped, for underrun retransmission
   always_ff @(negedge sclk or negedge rst_) begin
      if (!rst_)          last_q <= '0;
      else if (fifo_rd_nx) last_q <= SW'(fifo_data);
   end

   assign hold_c = last_q;
`else
   assign hold_c = '0;
`endif

   // Select the word to send and left-align it to the slot width
   always_comb begin
      src_c = fifo_empty ? hold_c : SW'(fifo_data);
      case (frame_size)
         2'b00: begin n_m1_c = CW'(15); src_al_c = src_c << 16; end
         2'b01: begin n_m1_c = CW'(23); src_al_c = src_c << 8;  end
         default: begin n_m1_c = CW'(31); src_al_c = src_c;     end
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state_q;
      shreg_nx    = shreg_q;
      cnt_nx      = cnt_q;
      sd_nx       = 1'b0;
      fifo_rd_nx  = 1'b0;
      ch_nx       = ch;
      underrun_nx = underrun & ~underrun_clr;
      if (!en_c) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (boundary_c) begin
         state_nx = SHIFT;
         sd_nx    = src_al_c[SW-1];
         shreg_nx = src_al_c << 1;
         cnt_nx   = n_m1_c;
         ch_nx    = wsx_c;
         if (fifo_empty) underrun_nx = 1'b1;
         else            fifo_rd_nx  = 1'b1;
      end else if (state_q == SHIFT && cnt_q != '0) begin
         sd_nx    = shreg_q[SW-1];
         shreg_nx = shreg_q << 1;
         cnt_nx   = cnt_q - CW'(1);
      end
   end

   // State, shifter and registered outputs, all on the falling sclk edge
   always_ff @(negedge sclk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         ws_q     <= 1'b0;
         wsx_q    <= 1'b0;
         en_q     <= 1'b0;
         sd       <= 1'b0;
         fifo_rd  <= 1'b0;
         ch       <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state_q  <= state_nx;
         shreg_q  <= shreg_nx;
         cnt_q    <= cnt_nx;
         ws_q     <= ws;
         wsx_q    <= wsx_c;
         en_q     <= en_c;
         sd       <= sd_nx;
         fifo_rd  <= fifo_rd_nx;
         ch       <= ch_nx;
         underrun <= underrun_nx;
      end
   end

endmodule
